// File: rtl/capture_csr_bank.sv
// capture_csr_bank: Avalon-MM CSR bank for NUM_CH capture engines.
//   Page 0 is global (ID, IRQ status/mask, 64-bit timestamp with coherent
//   LO/HI snapshot). Pages 1..NUM_CH hold one channel each (control, window
//   config, live status and counters, sticky DONE/WRAP events).
//   Reads have a fixed one-cycle latency signalled by readdatavalid.
// Optional feature: define CAPTURE_CSR_IRQ_EN to implement IRQ_STATUS,
//   IRQ_MASK and the registered irq output. Without it those registers read
//   0 and irq is tied low.
// TS_INIT is the timestamp reset value (0 in normal use).
module capture_csr_bank #(
  parameter int          N        = 32,
  parameter int          NUM_CH   = 2,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] ID_VALUE = 32'h7CD0_0002,
  parameter logic [63:0] TS_INIT  = 64'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  read,
  input  logic                  write,
  input  logic [N-1:0]          writedata,
  output logic [N-1:0]          readdata,
  output logic                  readdatavalid,
  input  logic [2*NUM_CH-1:0]   ch_state,
  input  logic [NUM_CH-1:0]     ch_busy,
  input  logic [NUM_CH-1:0]     ch_done,
  input  logic [NUM_CH-1:0]     ch_wrap,
  input  logic [N*NUM_CH-1:0]   ch_processing_cc,
  input  logic [N*NUM_CH-1:0]   ch_last_write_addr,
  output logic [NUM_CH-1:0]     ch_enable,
  output logic [NUM_CH-1:0]     ch_soft_rst,
  output logic [N*NUM_CH-1:0]   ch_pkt_begin,
  output logic [N*NUM_CH-1:0]   ch_pkt_end,
  output logic [N*NUM_CH-1:0]   ch_buf_start,
  output logic [N*NUM_CH-1:0]   ch_buf_size,
  output logic                  irq
);

  localparam int PAGE_W   = ADDR_W - 3;
  // Wide enough to slice both TS halves even when 2*N exceeds 64.
  localparam int TS_EXT_W = (2 * N > 64) ? 2 * N : 64;

  // Global page offsets
  localparam logic [2:0] G_ID     = 3'd0;
  localparam logic [2:0] G_IRQ_ST = 3'd1;
  localparam logic [2:0] G_IRQ_MK = 3'd2;
  localparam logic [2:0] G_TS_LO  = 3'd3;
  localparam logic [2:0] G_TS_HI  = 3'd4;

  // Channel page offsets
  localparam logic [2:0] C_CTRL   = 3'd0;
  localparam logic [2:0] C_STATUS = 3'd1;
  localparam logic [2:0] C_PKT_B  = 3'd2;
  localparam logic [2:0] C_PKT_E  = 3'd3;
  localparam logic [2:0] C_BUF_S  = 3'd4;
  localparam logic [2:0] C_BUF_Z  = 3'd5;
  localparam logic [2:0] C_LAST_W = 3'd6;
  localparam logic [2:0] C_PROC   = 3'd7;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [PAGE_W-1:0] page;
  logic [2:0]        off;
  logic              glb_sel;

  assign page    = address[ADDR_W-1:3];
  assign off     = address[2:0];
  assign glb_sel = (page == '0);

  // ---------------------------------------------------------------------
  // Per-channel event and clear vectors
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0]   ch_sel;
  logic [NUM_CH-1:0]   soft_req;
  logic [NUM_CH-1:0]   done_clr;
  logic [NUM_CH-1:0]   wrap_clr;
  logic [NUM_CH-1:0]   done_ev;
  logic [NUM_CH-1:0]   wrap_ev;
  logic [NUM_CH-1:0]   done_prev_q;
  logic [NUM_CH-1:0]   wrap_prev_q;
  logic [NUM_CH-1:0]   done_st_q;
  logic [NUM_CH-1:0]   done_st_d;
  logic [NUM_CH-1:0]   wrap_st_q;
  logic [NUM_CH-1:0]   wrap_st_d;
  logic [NUM_CH-1:0]   soft_rst_q;
  logic [N*NUM_CH-1:0] ch_rd_flat;

  // Rising-edge detection against last cycle's level
  assign done_ev = ch_done & ~done_prev_q;
  assign wrap_ev = ch_wrap & ~wrap_prev_q;

  // A new hardware event wins over a same-cycle software clear.
  assign done_st_d = done_ev | (done_st_q & ~done_clr);
  assign wrap_st_d = wrap_ev | (wrap_st_q & ~wrap_clr);

  // ---------------------------------------------------------------------
  // Channel register pages
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic         ch_wr;
    logic         ctrl_en_q;
    logic [N-1:0] pkt_begin_q;
    logic [N-1:0] pkt_end_q;
    logic [N-1:0] buf_start_q;
    logic [N-1:0] buf_size_q;
    logic [N-1:0] rd_local;

    assign ch_sel[gi]   = (page == PAGE_W'(gi + 1));
    assign ch_wr        = write & ch_sel[gi];
    // CTRL.bit1 requests a soft reset; it also wipes this channel's events.
    assign soft_req[gi] = ch_wr & (off == C_CTRL) & writedata[1];
    assign done_clr[gi] = (ch_wr & (off == C_STATUS) & writedata[3]) | soft_req[gi];
    assign wrap_clr[gi] = (ch_wr & (off == C_STATUS) & writedata[4]) | soft_req[gi];

    // Software-writable channel configuration (retained across soft reset)
    always_ff @(posedge clk) begin
      if (!reset) begin
        ctrl_en_q   <= 1'b0;
        pkt_begin_q <= '0;
        pkt_end_q   <= '0;
        buf_start_q <= '0;
        buf_size_q  <= '0;
      end else if (ch_wr) begin
        case (off)
          C_CTRL:  ctrl_en_q   <= writedata[0];
          C_PKT_B: pkt_begin_q <= writedata;
          C_PKT_E: pkt_end_q   <= writedata;
          C_BUF_S: buf_start_q <= writedata;
          C_BUF_Z: buf_size_q  <= writedata;
          default: ;
        endcase
      end
    end

    // Read view of this channel page; soft-reset bit always reads back 0
    always_comb begin
      rd_local = '0;
      case (off)
        C_CTRL:   rd_local = N'(ctrl_en_q);
        C_STATUS: rd_local = N'({wrap_st_q[gi], done_st_q[gi], ch_busy[gi],
                                 ch_state[2*gi +: 2]});
        C_PKT_B:  rd_local = pkt_begin_q;
        C_PKT_E:  rd_local = pkt_end_q;
        C_BUF_S:  rd_local = buf_start_q;
        C_BUF_Z:  rd_local = buf_size_q;
        C_LAST_W: rd_local = ch_last_write_addr[N*gi +: N];
        C_PROC:   rd_local = ch_processing_cc[N*gi +: N];
        default:  rd_local = '0;
      endcase
    end

    assign ch_rd_flat[N*gi +: N]   = rd_local;
    assign ch_enable[gi]           = ctrl_en_q;
    assign ch_pkt_begin[N*gi +: N] = pkt_begin_q;
    assign ch_pkt_end[N*gi +: N]   = pkt_end_q;
    assign ch_buf_start[N*gi +: N] = buf_start_q;
    assign ch_buf_size[N*gi +: N]  = buf_size_q;
  end

  // Edge history, sticky events and the soft-reset pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_prev_q <= '0;
      wrap_prev_q <= '0;
      done_st_q   <= '0;
      wrap_st_q   <= '0;
      soft_rst_q  <= '0;
    end else begin
      done_prev_q <= ch_done;
      wrap_prev_q <= ch_wrap;
      done_st_q   <= done_st_d;
      wrap_st_q   <= wrap_st_d;
      soft_rst_q  <= soft_req;
    end
  end

  assign ch_soft_rst = soft_rst_q;

  // ---------------------------------------------------------------------
  // Interrupt aggregation
  // ---------------------------------------------------------------------
`ifdef CAPTURE_CSR_IRQ_EN
  logic [NUM_CH-1:0] irq_st_q;
  logic [NUM_CH-1:0] irq_st_d;
  logic [NUM_CH-1:0] irq_mask_q;
  logic [NUM_CH-1:0] irq_clr;
  logic              irq_q;

  assign irq_clr  = ({NUM_CH{write & glb_sel & (off == G_IRQ_ST)}} & writedata[NUM_CH-1:0])
                  | soft_req;
  // Either event of a channel raises its status bit; set beats clear.
  assign irq_st_d = done_ev | wrap_ev | (irq_st_q & ~irq_clr);

  // IRQ status/mask registers and the registered interrupt level
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_st_q   <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_st_q <= irq_st_d;
      if (write && glb_sel && (off == G_IRQ_MK)) begin
        irq_mask_q <= writedata[NUM_CH-1:0];
      end
      irq_q <= |(irq_st_q & irq_mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------
  logic [63:0]       ts_q;
  logic [N-1:0]      ts_hi_q;
  logic [TS_EXT_W-1:0] ts_ext;

  assign ts_ext = TS_EXT_W'(ts_q);

  // Free-running counter; a TS_LO read snapshots the upper half for TS_HI
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q    <= TS_INIT;
      ts_hi_q <= '0;
    end else begin
      ts_q <= ts_q + 64'd1;
      if (read && glb_sel && (off == G_TS_LO)) begin
        ts_hi_q <= ts_ext[2*N-1:N];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [N-1:0] rd_val;
  logic [N-1:0] readdata_q;
  logic         readdatavalid_q;

  // Select the addressed register; anything unmapped reads as zero
  always_comb begin
    rd_val = '0;
    if (glb_sel) begin
      case (off)
        G_ID:     rd_val = N'(ID_VALUE);
`ifdef CAPTURE_CSR_IRQ_EN
        G_IRQ_ST: rd_val = N'(irq_st_q);
        G_IRQ_MK: rd_val = N'(irq_mask_q);
`endif
        G_TS_LO:  rd_val = ts_ext[N-1:0];
        G_TS_HI:  rd_val = ts_hi_q;
        default:  rd_val = '0;
      endcase
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel[k]) begin
        rd_val = ch_rd_flat[N*k +: N];
      end
    end
  end

  // One-cycle read response; data holds between reads
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= read;
      if (read) begin
        readdata_q <= rd_val;
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_capture_csr_bank.sv
// Self-checking bench for capture_csr_bank: directed scenarios followed by
// random bus/event traffic, all checked against a register-level model.
module tb_capture_csr_bank;

  localparam int          N        = 32;
  localparam int          NUM_CH   = 2;
  localparam int          ADDR_W   = 6;
  localparam int          SW       = 2 * NUM_CH;
  localparam int          CW       = N * NUM_CH;
  localparam logic [31:0] ID_VALUE = 32'h7CD0_0002;
  localparam logic [63:0] TS_INIT  = 64'hFFFF_FFFF_FFFF_FE00;
`ifdef CAPTURE_CSR_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [N-1:0]      writedata;
  logic [N-1:0]      readdata;
  logic              readdatavalid;
  logic [SW-1:0]     ch_state;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_wrap;
  logic [CW-1:0]     ch_processing_cc;
  logic [CW-1:0]     ch_last_write_addr;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] ch_soft_rst;
  logic [CW-1:0]     ch_pkt_begin;
  logic [CW-1:0]     ch_pkt_end;
  logic [CW-1:0]     ch_buf_start;
  logic [CW-1:0]     ch_buf_size;
  logic              irq;

  capture_csr_bank #(
    .N(N), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ID_VALUE(ID_VALUE), .TS_INIT(TS_INIT)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .ch_state(ch_state), .ch_busy(ch_busy), .ch_done(ch_done), .ch_wrap(ch_wrap),
    .ch_processing_cc(ch_processing_cc), .ch_last_write_addr(ch_last_write_addr),
    .ch_enable(ch_enable), .ch_soft_rst(ch_soft_rst), .ch_pkt_begin(ch_pkt_begin),
    .ch_pkt_end(ch_pkt_end), .ch_buf_start(ch_buf_start), .ch_buf_size(ch_buf_size),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (register-level view) ----------------
  logic [N-1:0]      m_cfg [NUM_CH][8];
  logic [NUM_CH-1:0] m_en, m_done, m_wrap, m_pdone, m_pwrap, m_irqs, m_mask;
  logic [63:0]       m_ts;
  logic [N-1:0]      m_hi, m_rd;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o < 8; o++) m_cfg[c][o] = '0;
    m_en = '0; m_done = '0; m_wrap = '0; m_pdone = '0; m_pwrap = '0;
    m_irqs = '0; m_mask = '0; m_ts = TS_INIT; m_hi = '0; m_rd = '0;
  endfunction

  function automatic logic [N-1:0] model_read(input logic [ADDR_W-1:0] a);
    int pg, of, c;
    logic [N-1:0] r;
    pg = int'(a) >> 3;
    of = int'(a) & 7;
    r  = '0;
    if (pg == 0) begin
      case (of)
        0: r = ID_VALUE;
        1: r = IRQ_EN ? N'(m_irqs) : '0;
        2: r = IRQ_EN ? N'(m_mask) : '0;
        3: r = m_ts[31:0];
        4: r = m_hi;
        default: r = '0;
      endcase
    end else if (pg <= NUM_CH) begin
      c = pg - 1;
      case (of)
        0: r = N'(m_en[c]);
        1: r = N'({m_wrap[c], m_done[c], ch_busy[c], ch_state[2*c +: 2]});
        6: r = ch_last_write_addr[N*c +: N];
        7: r = ch_processing_cc[N*c +: N];
        default: r = m_cfg[c][of];
      endcase
    end
    return r;
  endfunction

  // Advance model and DUT one clock with the currently driven inputs, then check.
  task automatic step();
    logic              exp_rdv, exp_irq, r, w;
    logic [NUM_CH-1:0] exp_soft, clr_d, clr_w, clr_i;
    logic [CW-1:0]     e_pb, e_pe, e_bs, e_bz;
    logic [ADDR_W-1:0] a;
    logic [N-1:0]      wd;
    int pg, of, c;
    r = read; w = write; a = address; wd = writedata;
    pg = int'(a) >> 3;
    of = int'(a) & 7;
    exp_soft = '0;
    if (!reset) begin
      model_reset();
      exp_rdv = 1'b0;
      exp_irq = 1'b0;
    end else begin
      exp_irq = IRQ_EN && (|(m_irqs & m_mask));
      exp_rdv = r;
      if (r) begin
        m_rd = model_read(a);
        if (pg == 0 && of == 3) m_hi = m_ts[63:32];
      end
      clr_d = '0; clr_w = '0; clr_i = '0;
      if (w) begin
        if (pg == 0 && of == 1) clr_i = wd[NUM_CH-1:0];
        else if (pg == 0 && of == 2) m_mask = IRQ_EN ? wd[NUM_CH-1:0] : '0;
        else if (pg >= 1 && pg <= NUM_CH) begin
          c = pg - 1;
          if (of == 0) begin
            m_en[c] = wd[0];
            if (wd[1]) begin
              exp_soft[c] = 1'b1; clr_d[c] = 1'b1; clr_w[c] = 1'b1; clr_i[c] = 1'b1;
            end
          end else if (of == 1) begin
            clr_d[c] = wd[3];
            clr_w[c] = wd[4];
          end else if (of >= 2 && of <= 5) begin
            m_cfg[c][of] = wd;
          end
        end
      end
      m_done = (m_done & ~clr_d) | (ch_done & ~m_pdone);
      m_wrap = (m_wrap & ~clr_w) | (ch_wrap & ~m_pwrap);
      m_irqs = IRQ_EN ? ((m_irqs & ~clr_i) | (ch_done & ~m_pdone) | (ch_wrap & ~m_pwrap)) : '0;
      m_pdone = ch_done;
      m_pwrap = ch_wrap;
      m_ts = m_ts + 64'd1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      e_pb[N*k +: N] = m_cfg[k][2];
      e_pe[N*k +: N] = m_cfg[k][3];
      e_bs[N*k +: N] = m_cfg[k][4];
      e_bz[N*k +: N] = m_cfg[k][5];
    end
    @(posedge clk);
    #1;
    check_eq("rdv", readdatavalid, exp_rdv);
    check_eq("rdata", readdata, m_rd);
    check_eq("irq", irq, exp_irq);
    check_eq("soft_rst", ch_soft_rst, exp_soft);
    check_eq("enable", ch_enable, m_en);
    check_eq("pkt_begin", ch_pkt_begin, e_pb);
    check_eq("pkt_end", ch_pkt_end, e_pe);
    check_eq("buf_start", ch_buf_start, e_bs);
    check_eq("buf_size", ch_buf_size, e_bz);
    if (r || w)
      $display("%0t %s%s addr=0x%0h wdata=0x%0h rdata=0x%0h rst_n=%0b", $time,
               r ? "R" : "-", w ? "W" : "-", a, wd, readdata, reset);
    @(negedge clk);
  endtask

  task automatic bus(input bit r, input bit w, input int a, input logic [N-1:0] d);
    read = r; write = w; address = ADDR_W'(a); writedata = d;
    step();
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    ch_state = '0; ch_busy = '0; ch_done = '0; ch_wrap = '0;
    ch_processing_cc = '0; ch_last_write_addr = '0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    reset = 1'b1;

    // T1: reset values, ID, unmapped page, valid only one cycle
    bus(1, 0, 0, '0);
    check_eq("t1_id", readdata, 64'(ID_VALUE));
    check_eq("t1_rdv", readdatavalid, 1);
    step();
    check_eq("t1_rdv_drop", readdatavalid, 0);
    for (int a = 8; a < 8 * (NUM_CH + 1); a++) begin
      bus(1, 0, a, '0);
      check_eq("t1_chreg", readdata, 0);
    end
    bus(1, 0, 8 * (NUM_CH + 1), '0);
    check_eq("t1_unmapped", readdata, 0);

    // T2: ch1 buffer window
    bus(0, 1, 20, 32'h3000_0000);
    bus(0, 1, 21, 32'h0010_0000);
    bus(1, 0, 20, '0);
    check_eq("t2_buf_start", readdata, 32'h3000_0000);
    bus(1, 0, 21, '0);
    check_eq("t2_buf_size", readdata, 32'h0010_0000);
    check_eq("t2_bs_port", ch_buf_start[2*N-1:N], 32'h3000_0000);
    bus(1, 0, 12, '0);
    check_eq("t2_ch0_untouched", readdata, 0);

    // Same-cycle write+read returns the old value
    bus(1, 1, 10, 32'hA5A5_0001);
    check_eq("rw_same_old", readdata, 0);
    bus(1, 0, 10, '0);
    check_eq("rw_same_new", readdata, 32'hA5A5_0001);

    // T3: done event, IRQ, W1C
    bus(0, 1, 2, 32'h1);
    ch_done = 2'b01;
    step();
    ch_done = 2'b00;
    step();
    check_eq("t3_irq_set", irq, IRQ_EN);
    bus(1, 0, 9, '0);
    check_eq("t3_status", readdata, 32'h8);
    bus(1, 0, 1, '0);
    check_eq("t3_irq_status", readdata, IRQ_EN ? 1 : 0);
    bus(0, 1, 9, 32'h8);
    bus(0, 1, 1, 32'h1);
    step();
    check_eq("t3_irq_clr", irq, 0);
    bus(1, 0, 9, '0);
    check_eq("t3_status_clr", readdata, 0);

    // T4: wrap edge coincident with W1C -> set wins; no re-set while held
    ch_wrap = 2'b10;
    bus(0, 1, 17, 32'h10);
    bus(1, 0, 17, '0);
    check_eq("t4_set_wins", readdata, 32'h10);
    bus(0, 1, 17, 32'h10);
    bus(1, 0, 17, '0);
    check_eq("t4_no_reset", readdata, 0);
    ch_wrap = 2'b00;
    bus(0, 1, 1, 32'h3);

    // T6: CTRL=3 -> enable, one soft-reset pulse, sticky bits cleared
    ch_done = 2'b01; ch_wrap = 2'b01;
    step();
    ch_done = 2'b00; ch_wrap = 2'b00;
    bus(0, 1, 8, 32'h3);
    check_eq("t6_soft_pulse", ch_soft_rst, 2'b01);
    check_eq("t6_enable", ch_enable, 2'b01);
    step();
    check_eq("t6_soft_once", ch_soft_rst, 0);
    bus(1, 0, 8, '0);
    check_eq("t6_ctrl_rd", readdata, 32'h1);
    bus(1, 0, 9, '0);
    check_eq("t6_sticky_clr", readdata, 0);
    bus(1, 0, 10, '0);
    check_eq("t6_cfg_kept", readdata, 32'hA5A5_0001);

    // Reset during an access: no response, write ignored
    read = 1'b1; write = 1'b1; address = 6'd11; writedata = 32'hFFFF_FFFF; reset = 1'b0;
    step();
    read = 1'b0; write = 1'b0;
    check_eq("rst_rdv_drop", readdatavalid, 0);
    reset = 1'b1;
    bus(1, 0, 11, '0);
    check_eq("rst_write_ignored", readdata, 0);

    // T5: coherent timestamp across the 32-bit and 64-bit rollover
    for (int i = 0; i < 2000 && m_ts[31:0] != 32'hFFFF_FFFE; i++) step();
    bus(1, 0, 3, '0);
    check_eq("t5_lo", readdata, 32'hFFFF_FFFE);
    step();
    step();
    bus(1, 0, 4, '0);
    check_eq("t5_hi_coherent", readdata, 32'hFFFF_FFFF);
    bus(1, 0, 3, '0);
    check_eq("t5_lo_wrapped", readdata, 32'h2);
    bus(1, 0, 4, '0);
    check_eq("t5_hi_wrapped", readdata, 0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      ch_state           = SW'($urandom);
      ch_busy            = NUM_CH'($urandom);
      ch_done            = NUM_CH'($urandom);
      ch_wrap            = NUM_CH'($urandom);
      ch_processing_cc   = {$urandom, $urandom};
      ch_last_write_addr = {$urandom, $urandom};
      reset              = ($urandom_range(0, 199) != 0);
      read               = ($urandom_range(0, 1) == 1);
      write              = ($urandom_range(0, 2) == 0);
      address            = ADDR_W'($urandom_range(0, 31));
      writedata          = $urandom;
      step();
    end
    read = 1'b0; write = 1'b0; reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
